intr_bus_arb: RTL

//  Interrupt/bus-request arbiter for the PDP-11 CPU. Compares BR4..BR7 requests against
//  the PSW priority (psw_in[7:5]), grants one level at an instruction boundary, and runs
//  the BG/vector handshake with a no-response timeout. Sits between iopage devices and the
//  CPU microsequencer; returns the captured vector for the trap sequence.

---
 rtl/intr_bus_arb.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/intr_bus_arb.sv
// PDP-11 interrupt/bus-request arbiter: BR4..BR7 vs PSW priority, BG/vector handshake with timeout.
// Optional DMA path (npr/npg, NPG state) is compiled in when NPR_EN is defined.
module intr_bus_arb #(
    parameter int TIMEOUT = 64,
    parameter int TW      = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] psw_in,
    input  logic [3:0]  br,
    input  logic        cpu_ready,
    input  logic        vec_valid,
    input  logic [8:0]  vec_in,
`ifdef NPR_EN
    input  logic        npr,
    output logic        npg,
`endif
    output logic        int_req,
    output logic [3:0]  bg,
    output logic [8:0]  int_vector,
    output logic        int_taken,
    output logic        int_abort
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_GRANT    = 2'd1;
    localparam logic [1:0] S_WAIT_REL = 2'd2;
`ifdef NPR_EN
    localparam logic [1:0] S_NPG      = 2'd3;
`endif

    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

    // One-hot grant for the highest requesting level strictly above the PSW priority.
    function automatic logic [3:0] pick_level(input logic [3:0] req, input logic [2:0] pri);
        logic [3:0] g;
        g = 4'b0000;
        if (req[3] && (pri < 3'd7))
            g = 4'b1000;
        else if (req[2] && (pri < 3'd6))
            g = 4'b0100;
        else if (req[1] && (pri < 3'd5))
            g = 4'b0010;
        else if (req[0] && (pri < 3'd4))
            g = 4'b0001;
        return g;
    endfunction

    logic [1:0]    state_q, state_d;
    logic [3:0]    bg_q, bg_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [8:0]    vec_q, vec_d;
    logic          taken_q, taken_d;
    logic          abort_q, abort_d;
    logic          req_q, req_d;
`ifdef NPR_EN
    logic          npg_q, npg_d;
`endif

    logic [3:0] elig;
    logic       unused_bits;

    assign elig        = pick_level(br, psw_in[7:5]);
    assign unused_bits = ^{psw_in[15:8], psw_in[4:0], vec_in[1:0]};

    always_comb begin
        state_d = state_q;
        bg_d    = bg_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        taken_d = 1'b0;
        abort_d = 1'b0;
        req_d   = |elig;
`ifdef NPR_EN
        npg_d   = npg_q;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef NPR_EN
                if (npr) begin
                    npg_d   = 1'b1;
                    state_d = S_NPG;
                end else
`endif
                if (cpu_ready && (|elig)) begin
                    bg_d    = elig;
                    cnt_d   = '0;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                // Capture beats passive release and timeout in the same cycle.
                if (vec_valid) begin
                    vec_d   = {vec_in[8:2], 2'b00};
                    taken_d = 1'b1;
                    bg_d    = 4'b0000;
                    state_d = S_WAIT_REL;
                end else if ((br & bg_q) == 4'b0000) begin
                    bg_d    = 4'b0000;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    abort_d = 1'b1;
                    bg_d    = 4'b0000;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_WAIT_REL: begin
                if (!vec_valid)
                    state_d = S_IDLE;
            end
`ifdef NPR_EN
            S_NPG: begin
                if (!npr) begin
                    npg_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
`endif
            default: begin
                bg_d    = 4'b0000;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            bg_q    <= 4'b0000;
            cnt_q   <= '0;
            vec_q   <= 9'd0;
            taken_q <= 1'b0;
            abort_q <= 1'b0;
            req_q   <= 1'b0;
`ifdef NPR_EN
            npg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bg_q    <= bg_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            taken_q <= taken_d;
            abort_q <= abort_d;
            req_q   <= req_d;
`ifdef NPR_EN
            npg_q   <= npg_d;
`endif
        end
    end

    assign int_req    = req_q;
    assign bg         = bg_q;
    assign int_vector = vec_q;
    assign int_taken  = taken_q;
    assign int_abort  = abort_q;
`ifdef NPR_EN
    assign npg        = npg_q;
`endif

endmodule
